// File: rtl/mem_image_loader.sv
// mem_image_loader
// Boot-time loader for the 1K x 16 program/data memory. It takes a byte
// stream made of a 16-bit length N, N big-endian 16-bit words and a 16-bit
// checksum. The words go to addresses 0..N-1. The loader then reads the
// image back and compares its wrap-around sum with the trailer. The CPU is
// held in reset until the image has been verified.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   byte_valid/data   upstream byte stream
//   byte_ready        loader accepts the byte this cycle
//   mem_w_en/addr     memory write port and address (the address is shared
//     /d_in           with the read-back)
//   mem_d_out         combinational read data from the memory
//   cpu_hold          high while loading or in ERROR
//   done / error      image verified / bad length or checksum
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | receive length high byte
// LEN_LO | receive length low byte, range check
// DAT_HI | receive data word high byte
// DAT_LO | receive data word low byte, present word to memory
// WRITE  | one-cycle memory write strobe
// CK_HI  | receive checksum high byte
// CK_LO  | receive checksum low byte
// VERIFY | read back one word per cycle and accumulate the sum
// CMP    | compare the sum with the checksum
// DONE   | image verified, CPU released
// ERROR  | bad length or checksum, CPU held
module mem_image_loader #(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_d_in,
  input  logic [WORD_W-1:0] mem_d_out,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // The index gets one extra bit so that a full-size image (N = 2^ADDR_W)
  // can reach its terminal count.
  localparam int          IDX_W = ADDR_W + 1;
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE,
    CK_HI, CK_LO, VERIFY, CMP, DONE, ERROR
  } state_t;

  state_t            state;
  logic [7:0]        hi_byte;   // first byte of the length, word or checksum being assembled
  logic [IDX_W-1:0]  n_words;
  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] ck_word;

  logic              xfer;
  logic [15:0]       pair_word;
  logic [IDX_W-1:0]  index_nxt;

  assign byte_ready = state inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CK_HI, CK_LO};
  assign xfer       = byte_valid && byte_ready;
  assign pair_word  = {hi_byte, byte_data};
  assign index_nxt  = index + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hi_byte  <= '0;
      n_words  <= '0;
      index    <= '0;
      sum      <= '0;
      ck_word  <= '0;
      mem_w_en <= 1'b0;
      mem_addr <= '0;
      mem_d_in <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            index    <= '0;
            sum      <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            if (pair_word == 16'd0 || pair_word > MAX_N) begin
              error    <= 1'b1;
              cpu_hold <= 1'b1;
              state    <= ERROR;
            end else begin
              n_words <= IDX_W'(pair_word);
              state   <= DAT_HI;
            end
          end
        end
        DAT_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
            state   <= DAT_LO;
          end
        end
        DAT_LO: begin
          if (xfer) begin
            mem_d_in <= WORD_W'(pair_word);
            mem_addr <= index[ADDR_W-1:0];
            mem_w_en <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          mem_w_en <= 1'b0;
          index    <= index_nxt;
          state    <= (index_nxt == n_words) ? CK_HI : DAT_HI;
        end
        CK_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
            state   <= CK_LO;
          end
        end
        CK_LO: begin
          if (xfer) begin
            ck_word  <= WORD_W'(pair_word);
            index    <= '0;
            sum      <= '0;
            mem_addr <= '0;
            state    <= VERIFY;
          end
        end
        VERIFY: begin
          // mem_d_out reflects mem_addr (== index) during this cycle.
          sum      <= sum + mem_d_out;
          index    <= index_nxt;
          mem_addr <= index_nxt[ADDR_W-1:0];
          if (index_nxt == n_words) state <= CMP;
        end
        CMP: begin
          if (sum == ck_word) begin
            done     <= 1'b1;
            error    <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= DONE;
          end else begin
            done     <= 1'b0;
            error    <= 1'b1;
            cpu_hold <= 1'b1;
            state    <= ERROR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
